z_accum_buffer: RTL and testbench

Parametrised successor to the single-port Z store in the fused softmax engine. Holds one Z_j accumulator per query index and adds an accumulate mode: overwrite or saturating read-modify-write on a valid/ready write port, plus an independent registered read port. Memory clearing is a hardware sweep sequencer rather than an array reset, so the store can be built from non-resettable RAM or flops. It sits between the MAC/exponent stage, which writes partial Z values, and the normaliser, which reads them back.

---
 rtl/fse_pkg.sv | 30 +++
 rtl/z_buf_regfile.sv | 32 +++
 rtl/z_accum_buffer.sv | 195 +++++++++++++++++++
 tb/tb_z_accum_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fse_pkg.sv
// Shared definitions for the fused softmax engine Z store.
//   z_buf_state_e : sweep/idle/drain sequencer states of z_accum_buffer
//   sat_add       : width-parametrised unsigned saturating add
package fse_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        DRAIN = 2'd2
    } z_buf_state_e;

    // Saturating add on operands up to 63 bits wide. 'width' selects the
    // result width; bit 64 of the return value flags that the result was
    // clamped to all-ones, bits [63:0] hold the (clamped) sum.
    function automatic logic [64:0] sat_add(
        input logic [63:0]  old_v,
        input logic [63:0]  inc,
        input int unsigned  width
    );
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, old_v} + {1'b0, inc};
        lim = (65'd1 << width) - 65'd1;
        if (sum > lim) begin
            return {1'b1, lim[63:0]};
        end
        return {1'b0, sum[63:0]};
    endfunction

endpackage

// File: rtl/z_buf_regfile.sv
// Non-resettable storage array for the Z accumulators.
//   i_clk             : write clock (posedge)
//   i_we/i_waddr/i_wdata : synchronous write port
//   i_raddr0/o_rdata0 : asynchronous read port (write pipeline old-value fetch)
//   i_raddr1/o_rdata1 : asynchronous read port (external read path)
module z_buf_regfile #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr0,
    output logic [WIDTH-1:0]      o_rdata0,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    output logic [WIDTH-1:0]      o_rdata1
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/z_accum_buffer.sv
// Z_j accumulator store: one entry per query index.
//   clk, rst_                    : clock, async active-low reset
//   wr_valid/wr_ready            : write handshake; wr_addr, wr_data, wr_acc
//                                  select entry, unsigned increment, mode
//                                  (1 = saturating accumulate, 0 = overwrite)
//   rd_en/rd_addr                : read request (no backpressure)
//   rd_data/rd_data_valid        : registered read result, one cycle later
//   clr_start                    : request full clear sweep (honoured in IDLE)
//   busy                         : drain or clear sweep in progress
//   clr_done                     : pulse during the last sweep write
//   sat                          : sticky saturation flag, cleared by a sweep
// ACC_WIDTH must be >= PROD_WIDTH and <= 63.
module z_accum_buffer
    import fse_pkg::*;
#(
    parameter int unsigned PROD_WIDTH      = 16,
    parameter int unsigned ACC_WIDTH       = 24,
    parameter int unsigned MAX_NUM_QUERIES = 256,
    parameter int unsigned ADDR_WIDTH      = $clog2(MAX_NUM_QUERIES)
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [PROD_WIDTH-1:0] wr_data,
    input  logic                  wr_acc,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ACC_WIDTH-1:0]  rd_data,
    output logic                  rd_data_valid,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done,
    output logic                  sat
);

    z_buf_state_e r_state;
    z_buf_state_e w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  w_sweep_last;
    logic                  w_accept;

    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [PROD_WIDTH-1:0] r_s1_data;
    logic                  r_s1_acc;
    logic [ACC_WIDTH-1:0]  r_s1_old;

    logic [64:0]           w_sum;
    logic                  w_unused_sum;
    logic [ACC_WIDTH-1:0]  w_s1_new;
    logic                  w_s1_ovf;

    logic [ACC_WIDTH-1:0]  w_mem_old;
    logic [ACC_WIDTH-1:0]  w_mem_rd;
    logic [ACC_WIDTH-1:0]  w_old;
    logic [ACC_WIDTH-1:0]  w_rd_val;

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ACC_WIDTH-1:0]  w_wdata;

    logic [ACC_WIDTH-1:0]  r_rd_data;
    logic                  r_rd_valid;
    logic                  r_sat;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        wr_ready     = 1'b0;
        w_sweep_last = 1'b0;
        case (r_state)
            CLEAR: begin
                w_sweep_last = (r_cnt == ADDR_WIDTH'(MAX_NUM_QUERIES - 1));
                if (w_sweep_last) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                wr_ready = !clr_start;
                if (clr_start) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = CLEAR;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign clr_done = w_sweep_last;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= w_sweep_last ? '0 : r_cnt + ADDR_WIDTH'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // ---------------- write pipeline ----------------
    assign w_accept = wr_valid & wr_ready;

    assign w_sum        = sat_add(64'(r_s1_old), 64'(r_s1_data), ACC_WIDTH);
    assign w_unused_sum = ^w_sum[63:ACC_WIDTH];
    assign w_s1_new     = r_s1_acc ? w_sum[ACC_WIDTH-1:0] : ACC_WIDTH'(r_s1_data);
    assign w_s1_ovf     = r_s1_acc & w_sum[64];

    // Stage 1 has not committed yet, so both the pipeline fetch and the
    // external read must take its result when the addresses match.
    assign w_old    = (r_s1_valid && (r_s1_addr == wr_addr)) ? w_s1_new : w_mem_old;
    assign w_rd_val = (r_s1_valid && (r_s1_addr == rd_addr)) ? w_s1_new : w_mem_rd;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_addr <= wr_addr;
            r_s1_data <= wr_data;
            r_s1_acc  <= wr_acc;
            r_s1_old  <= w_old;
        end
    end

    // Sweep writes and stage-1 commits never coincide: nothing is accepted
    // in DRAIN or CLEAR, so stage 1 is empty for the whole sweep.
    assign w_we    = r_s1_valid | (r_state == CLEAR);
    assign w_waddr = r_s1_valid ? r_s1_addr : r_cnt;
    assign w_wdata = r_s1_valid ? w_s1_new : '0;

    z_buf_regfile #(
        .DEPTH      (MAX_NUM_QUERIES),
        .WIDTH      (ACC_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .i_clk    (clk),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_raddr0 (wr_addr),
        .o_rdata0 (w_mem_old),
        .i_raddr1 (rd_addr),
        .o_rdata1 (w_mem_rd)
    );

    // ---------------- read port and status ----------------
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en && (r_state == IDLE);
            if (rd_en && (r_state == IDLE)) begin
                r_rd_data <= w_rd_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_sat <= 1'b0;
        end else if (w_sweep_last) begin
            r_sat <= 1'b0;
        end else if (r_s1_valid && w_s1_ovf) begin
            r_sat <= 1'b1;
        end
    end

    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_valid;
    assign sat           = r_sat;

endmodule

// File: tb/tb_z_accum_buffer.sv
// Self-checking bench for z_accum_buffer (default parameters).
// A transaction-level model applies each accepted write atomically and
// clears the whole store at the end of a sweep; a negedge process compares
// every output against it each cycle. Directed sequences add literal checks.
module tb_z_accum_buffer;

    logic        clk;
    logic        rst_;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_acc;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [23:0] rd_data;
    logic        rd_data_valid;
    logic        clr_start;
    logic        busy;
    logic        clr_done;
    logic        sat;

    int total = 0;
    int bad   = 0;

    z_accum_buffer #(
        .PROD_WIDTH      (16),
        .ACC_WIDTH       (24),
        .MAX_NUM_QUERIES (256)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_acc        (wr_acc),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .clr_start     (clr_start),
        .busy          (busy),
        .clr_done      (clr_done),
        .sat           (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_left: busy cycles still to go (0 = idle). A sweep request costs
    // 1 drain cycle + 256 clear cycles; power-up costs 256.
    int unsigned m_left = 256;
    bit          m_sat  = 1'b0;
    bit          m_pend = 1'b0;
    logic [23:0] m_rd   = 24'h0;
    bit          m_rdv  = 1'b0;
    logic [23:0] m_mem [256];
    bit          m_busy;
    int          m_sum;

    always @(posedge clk) begin
        if (!rst_) begin
            m_left = 256;
            m_sat  = 1'b0;
            m_pend = 1'b0;
            m_rd   = 24'h0;
            m_rdv  = 1'b0;
        end else begin
            m_busy = (m_left != 0);
            // reads see everything accepted before this cycle
            if (rd_en && !m_busy) begin
                m_rd  = m_mem[rd_addr];
                m_rdv = 1'b1;
            end else begin
                m_rdv = 1'b0;
            end
            // overflow shows on sat two cycles after the accept
            m_sat  = m_sat | m_pend;
            m_pend = 1'b0;
            if (wr_valid && !m_busy && !clr_start) begin
                if (wr_acc) begin
                    m_sum = int'(m_mem[wr_addr]) + int'(wr_data);
                    if (m_sum > 32'h00FF_FFFF) begin
                        m_sum  = 32'h00FF_FFFF;
                        m_pend = 1'b1;
                    end
                end else begin
                    m_sum = int'(wr_data);
                end
                m_mem[wr_addr] = m_sum[23:0];
            end
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_sat = 1'b0;
                    foreach (m_mem[i]) m_mem[i] = 24'h0;
                end
            end else if (clr_start) begin
                m_left = 257;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",      busy,          m_left != 0);
        chk("wr_ready",  wr_ready,      (m_left == 0) && !clr_start);
        chk("clr_done",  clr_done,      m_left == 1);
        chk("sat",       sat,           m_sat);
        chk("rd_valid",  rd_data_valid, m_rdv);
        chk("rd_data",   rd_data,       m_rd);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic acc);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_acc   = acc;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int dones;
        logic [23:0] orv;

        rst_      = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_acc    = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        clr_start = 1'b0;
        #22;
        rst_ = 1'b1;

        // power-up sweep: exactly 256 busy cycles, one clr_done on the last
        n = 0;
        dones = 0;
        while (busy && n < 400) begin
            if (clr_done) dones++;
            n++;
            tick();
        end
        chk("boot_busy_cycles", n, 256);
        chk("boot_clr_done_count", dones, 1);
        chk("boot_wr_ready", wr_ready, 1);

        do_read(8'd17);
        chk("read17_valid", rd_data_valid, 1);
        chk("read17_data", rd_data, 24'h000000);

        // overwrite then accumulate, read right behind the accumulate
        do_write(8'd5, 16'h0100, 1'b0);
        do_write(8'd5, 16'h0020, 1'b1);
        do_read(8'd5);
        chk("addr5_data", rd_data, 24'h000120);

        // back-to-back accumulates exercise stage-1 forwarding
        for (int i = 0; i < 4; i++) do_write(8'd3, 16'hFFFF, 1'b1);
        do_read(8'd3);
        chk("addr3_data", rd_data, 24'h03FFFC);

        // 257 x 0xFFFF overflows 24 bits on the final accumulate
        do_write(8'd9, 16'hFFFF, 1'b0);
        for (int i = 0; i < 256; i++) do_write(8'd9, 16'hFFFF, 1'b1);
        do_read(8'd9);
        chk("addr9_sat_data", rd_data, 24'hFFFFFF);
        chk("addr9_sat_flag", sat, 1);

        clr_start = 1'b1;
        #1;
        chk("clr_ready_drop", wr_ready, 0);
        tick();
        clr_start = 1'b0;
        k = 1;
        while (!clr_done && k < 400) begin
            tick();
            k++;
        end
        chk("clr_done_latency", k, 257);
        tick();
        chk("sat_cleared", sat, 0);
        chk("idle_after_clear", busy, 0);

        // clear request while a write sits in stage 1
        wr_valid = 1'b1;
        wr_addr  = 8'd11;
        wr_data  = 16'h0055;
        wr_acc   = 1'b0;
        tick();
        clr_start = 1'b1;
        #1;
        chk("pending_ready_drop", wr_ready, 0);
        tick();
        clr_start = 1'b0;
        wr_valid  = 1'b0;
        k = 0;
        // reads and clr_start during the sweep must be ignored
        while (busy && k < 400) begin
            rd_en     = 1'b1;
            rd_addr   = 8'd9;
            clr_start = (k == 10);
            tick();
            k++;
        end
        clr_start = 1'b0;
        rd_en     = 1'b0;
        chk("sweep2_busy_cycles", k, 257);

        orv = '0;
        for (int a = 0; a < 256; a++) begin
            rd_en   = 1'b1;
            rd_addr = 8'(a);
            tick();
            orv = orv | rd_data;
        end
        rd_en = 1'b0;
        chk("sweep2_all_zero", orv, 24'h0);

        // same-cycle read and write: read sees the old value
        do_write(8'd7, 16'h0010, 1'b0);
        tick();
        wr_valid = 1'b1;
        wr_addr  = 8'd7;
        wr_data  = 16'h0020;
        wr_acc   = 1'b0;
        rd_en    = 1'b1;
        rd_addr  = 8'd7;
        tick();
        wr_valid = 1'b0;
        chk("rw_same_cycle_old", rd_data, 24'h000010);
        tick();
        rd_en = 1'b0;
        chk("rw_next_cycle_new", rd_data, 24'h000020);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
